call_stack: RTL and testbench

CALL_STACK -- requirements
Module: call_stack

---
 rtl/call_stack_pkg.sv | 15 +
 rtl/stack_ram.sv | 31 +++
 rtl/call_stack.sv | 114 +++++++++++
 tb/tb_call_stack.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/call_stack_pkg.sv
// Shared call-stack definitions: opcode encodings and overflow policies,
// used by the stack itself and by the program-counter/sequencer logic.
package call_stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_NOP  = 2'd2,
    OP_REPL = 2'd3
  } op_e;

  localparam int OVF_DISCARD = 0;  // push on full overwrites the oldest entry
  localparam int OVF_REJECT  = 1;  // push on full is dropped

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register file: one write port, combinational read,
// asynchronous active-low clear of every entry.
module stack_ram #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '0;
    else      mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack: circular buffer addressed by a top pointer,
// with sticky overflow/underflow flags and a selectable push-on-full policy.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int WIDTH    = 11,
  parameter int DEPTH    = 2,
  parameter int OVF_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 op,
  input  logic [WIDTH-1:0]           din,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       udf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc, ptr_dec, waddr;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             ovf_ev, udf_ev, we, is_empty, is_full;
  logic [WIDTH-1:0] rdata;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign ptr_inc  = (ptr_q == PW'(DEPTH-1)) ? '0 : ptr_q + PW'(1);
  assign ptr_dec  = (ptr_q == '0) ? PW'(DEPTH-1) : ptr_q - PW'(1);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    we      = 1'b0;
    waddr   = ptr_inc;
    ovf_ev  = 1'b0;
    udf_ev  = 1'b0;
    case (op_e'(op))
      OP_PUSH: begin
        if (!is_full) begin
          we      = 1'b1;
          ptr_d   = ptr_inc;
          count_d = count_q + CW'(1);
        end else begin
          ovf_ev = 1'b1;
          // When full, the slot after the top holds the oldest entry.
          if (OVF_MODE == OVF_DISCARD) begin
            we    = 1'b1;
            ptr_d = ptr_inc;
          end
        end
      end
      OP_POP: begin
        if (!is_empty) begin
          ptr_d   = ptr_dec;
          count_d = count_q - CW'(1);
        end else begin
          udf_ev = 1'b1;
        end
      end
      OP_REPL: begin
        we = 1'b1;
        if (!is_empty) begin
          waddr = ptr_q;
        end else begin
          ptr_d   = ptr_inc;
          count_d = CW'(1);
        end
      end
      default: ;
    endcase
    // A new error on the same edge as clr_err leaves the flag set.
    ovf_d = ovf_ev | (ovf_q & ~clr_err);
    udf_d = udf_ev | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (ptr_q),
    .rdata (rdata)
  );

  assign top   = is_empty ? '0 : rdata;
  assign count = count_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_call_stack.sv
// Three call_stack instances (D2/discard, D4/reject, D3/discard) share one
// stimulus stream and are compared against a list-based reference model.
module tb_call_stack;
  import call_stack_pkg::*;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   op = OP_NOP;
  logic [W-1:0] din = '0;
  logic         clr_err = 1'b0;

  logic [W-1:0] top2, top4, top3;
  logic [1:0]   cnt2, cnt3;
  logic [2:0]   cnt4;
  logic         e2, f2, o2, u2, e4, f4, o4, u4, e3, f3, o3, u3;

  int errors = 0;
  int checks = 0;

  int dep [3] = '{2, 4, 3};
  int mode[3] = '{0, 1, 0};
  int stk [3][16];   // stk[i][0] is the oldest entry
  int mcnt[3];
  bit movf[3], mudf[3];

  always #5 clk = ~clk;

  call_stack #(.WIDTH(W), .DEPTH(2), .OVF_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .op(op), .din(din), .clr_err(clr_err),
    .top(top2), .count(cnt2), .empty(e2), .full(f2), .ovf(o2), .udf(u2));
  call_stack #(.WIDTH(W), .DEPTH(4), .OVF_MODE(1)) dut4 (
    .clk(clk), .rst(rst), .op(op), .din(din), .clr_err(clr_err),
    .top(top4), .count(cnt4), .empty(e4), .full(f4), .ovf(o4), .udf(u4));
  call_stack #(.WIDTH(W), .DEPTH(3), .OVF_MODE(0)) dut3 (
    .clk(clk), .rst(rst), .op(op), .din(din), .clr_err(clr_err),
    .top(top3), .count(cnt3), .empty(e3), .full(f3), .ovf(o3), .udf(u3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_dut(input int i, output logic [31:0] t, output logic [31:0] c,
                          output logic [31:0] e, output logic [31:0] f,
                          output logic [31:0] o, output logic [31:0] u);
    case (i)
      0: begin t = {21'b0, top2}; c = {30'b0, cnt2}; e = {31'b0, e2}; f = {31'b0, f2};
               o = {31'b0, o2}; u = {31'b0, u2}; end
      1: begin t = {21'b0, top4}; c = {29'b0, cnt4}; e = {31'b0, e4}; f = {31'b0, f4};
               o = {31'b0, o4}; u = {31'b0, u4}; end
      default: begin t = {21'b0, top3}; c = {30'b0, cnt3}; e = {31'b0, e3}; f = {31'b0, f3};
               o = {31'b0, o3}; u = {31'b0, u3}; end
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0; movf[i] = 1'b0; mudf[i] = 1'b0;
      for (int j = 0; j < 16; j++) stk[i][j] = 0;
    end
  endtask

  task automatic model_step(input logic [1:0] o, input int d, input bit clr);
    for (int i = 0; i < 3; i++) begin
      bit oe = 1'b0, ue = 1'b0;
      case (o)
        OP_PUSH: begin
          if (mcnt[i] < dep[i]) begin
            stk[i][mcnt[i]] = d; mcnt[i]++;
          end else begin
            oe = 1'b1;
            if (mode[i] == 0) begin
              for (int j = 0; j < dep[i] - 1; j++) stk[i][j] = stk[i][j+1];
              stk[i][dep[i]-1] = d;
            end
          end
        end
        OP_POP:  if (mcnt[i] > 0) mcnt[i]--; else ue = 1'b1;
        OP_REPL: if (mcnt[i] > 0) stk[i][mcnt[i]-1] = d;
                 else begin stk[i][0] = d; mcnt[i] = 1; end
        default: ;
      endcase
      movf[i] = oe | (movf[i] & !clr);
      mudf[i] = ue | (mudf[i] & !clr);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] t, c, e, f, o, u;
    for (int i = 0; i < 3; i++) begin
      int et;
      read_dut(i, t, c, e, f, o, u);
      et = (mcnt[i] > 0) ? stk[i][mcnt[i]-1] : 0;
      chk($sformatf("%s/d%0d top", tag, dep[i]), t, et);
      chk($sformatf("%s/d%0d count", tag, dep[i]), c, mcnt[i]);
      chk($sformatf("%s/d%0d empty", tag, dep[i]), e, (mcnt[i] == 0) ? 1 : 0);
      chk($sformatf("%s/d%0d full", tag, dep[i]), f, (mcnt[i] == dep[i]) ? 1 : 0);
      chk($sformatf("%s/d%0d ovf", tag, dep[i]), o, {31'b0, movf[i]});
      chk($sformatf("%s/d%0d udf", tag, dep[i]), u, {31'b0, mudf[i]});
    end
  endtask

  task automatic step(input logic [1:0] o, input int d, input bit clr, input string tag);
    op = o; din = d[W-1:0]; clr_err = clr;
    @(posedge clk); #1;
    model_step(o, d, clr);
    op = OP_NOP; clr_err = 1'b0;
    check_all(tag);
  endtask

  // Asserts reset away from any clock edge and checks outputs before an edge can occur.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    int exp_tops[4] = '{3, 2, 1, 0};
    #3 model_reset();
    check_all("por");
    @(negedge clk) rst = 1'b1;

    // Basic push/pop
    step(OP_PUSH, 'h123, 0, "p1"); chk("r30 top a", {21'b0, top2}, 'h123);
    step(OP_PUSH, 'h456, 0, "p2"); chk("r30 top b", {21'b0, top2}, 'h456);
    step(OP_POP,  0,     0, "q1"); chk("r30 top c", {21'b0, top2}, 'h123);
    step(OP_POP,  0,     0, "q2"); chk("r30 top d", {21'b0, top2}, 0);

    // Discard-oldest on a full depth-2 stack
    do_reset("rst31");
    step(OP_PUSH, 1, 0, "o1");
    step(OP_PUSH, 2, 0, "o2");
    step(OP_PUSH, 3, 0, "o3");
    chk("r31 ovf", {31'b0, o2}, 1); chk("r31 cnt", {30'b0, cnt2}, 2);
    step(OP_POP, 0, 0, "o4"); chk("r31 top a", {21'b0, top2}, 2);
    step(OP_POP, 0, 0, "o5"); chk("r31 top b", {21'b0, top2}, 0);

    // Reject-on-full, depth 4
    do_reset("rst32");
    for (int v = 1; v <= 5; v++) step(OP_PUSH, v, 0, "r32p");
    chk("r32 top", {21'b0, top4}, 4); chk("r32 cnt", {29'b0, cnt4}, 4);
    chk("r32 full", {31'b0, f4}, 1);  chk("r32 ovf", {31'b0, o4}, 1);
    for (int k = 0; k < 4; k++) begin
      step(OP_POP, 0, 0, "r32q");
      chk($sformatf("r32 pop%0d top", k), {21'b0, top4}, exp_tops[k]);
    end

    // Underflow and clear/set priority
    do_reset("rst33");
    step(OP_POP, 0, 0, "u1");
    chk("r33 udf", {31'b0, u2}, 1); chk("r33 top", {21'b0, top2}, 0);
    step(OP_POP, 0, 1, "u2"); chk("r33 setwins", {31'b0, u2}, 1);
    step(OP_NOP, 0, 1, "u3"); chk("r33 clr", {31'b0, u2}, 0);

    // Replace
    do_reset("rst34");
    step(OP_PUSH, 'h0AA, 0, "x1");
    step(OP_REPL, 'h055, 0, "x2");
    chk("r34 top a", {21'b0, top2}, 'h055); chk("r34 cnt a", {30'b0, cnt2}, 1);
    step(OP_POP,  0,     0, "x3");
    step(OP_REPL, 'h077, 0, "x4");
    chk("r34 top b", {21'b0, top2}, 'h077); chk("r34 cnt b", {30'b0, cnt2}, 1);
    chk("r34 noflag", {30'b0, o2, u2}, 0);

    // Random mixed traffic across pointer wraps
    do_reset("rst35");
    for (int n = 0; n < 60; n++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] o;
      if (r < 4)      o = OP_PUSH;
      else if (r < 7) o = OP_POP;
      else if (r < 9) o = OP_REPL;
      else            o = OP_NOP;
      step(o, $urandom_range(0, 2047), ($urandom_range(0, 7) == 0), "rnd");
    end

    // Mid-cycle reset on a populated stack, then first op after release
    step(OP_PUSH, 'h3C3, 0, "pre");
    do_reset("rstmid");
    step(OP_PUSH, 'h05A, 0, "post");
    chk("post top", {21'b0, top3}, 'h05A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
